// File: rtl/debug_cfg_types_pkg.sv
// Shared types for the debug module: abstract command FSM states, cmderr codes,
// register layouts of abstract_command / abstractcs and the supported regno ranges.
package debug_cfg_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2
    } abstract_cmd_state_t;

    typedef enum logic [2:0] {
        NONE          = 3'd0,
        BUSY          = 3'd1,
        NOT_SUPPORTED = 3'd2,
        EXCEPTION     = 3'd3,
        HALT_RESUME   = 3'd4,
        OTHER         = 3'd7
    } cmderr_t;

    localparam logic [15:0] GPR_BASE = 16'h1000;
    localparam logic [15:0] GPR_LAST = 16'h101F;
    localparam logic [15:0] CSR_LAST = 16'h0FFF;

    localparam logic [7:0] ACCESS_REGISTER = 8'd0;
    localparam logic [2:0] AARSIZE_32      = 3'd2;
    localparam logic [3:0] DATACOUNT       = 4'd1;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        reserved0;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } abstract_command_t;

    typedef struct packed {
        logic [2:0]  zero3;
        logic [4:0]  progbufsize;
        logic [10:0] zero2;
        logic        busy;
        logic        zero1;
        logic [2:0]  cmderr;
        logic [3:0]  zero0;
        logic [3:0]  datacount;
    } abstract_control_and_status_t;

    function automatic logic regno_supported(input logic [15:0] regno);
        return (regno <= CSR_LAST) || ((regno >= GPR_BASE) && (regno <= GPR_LAST));
    endfunction

endpackage

// File: rtl/debug_abstract_cmd_ctrl_decode.sv
// Combinational validation of a latched Access Register command against the
// selected hart; yields the cmderr to raise and whether a hart access is needed.
module debug_abstract_cmd_decode
    import debug_cfg_types::*;
#(
    parameter int NUM_HARTS  = 4,
    parameter int HARTSELLEN = 9
) (
    input  abstract_command_t     cmd_i,
    input  logic [HARTSELLEN-1:0] hartsel_i,
    input  logic [NUM_HARTS-1:0]  hart_halted_i,
    output cmderr_t               err_o,
    output logic                  no_transfer_o
);

    logic sel_halted;
    logic unused_cmd_bits;

    // Postincrement and the reserved bit carry no meaning for a single access.
    assign unused_cmd_bits = ^{cmd_i.reserved0, cmd_i.aarpostincrement};

    always_comb begin
        // Harts outside 0..NUM_HARTS-1 never match, so they read as not halted.
        sel_halted = 1'b0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (hartsel_i == HARTSELLEN'(i)) begin
                sel_halted = hart_halted_i[i];
            end
        end

        err_o = NONE;
        if ((cmd_i.cmdtype != ACCESS_REGISTER) || (cmd_i.aarsize != AARSIZE_32) || cmd_i.postexec) begin
            err_o = NOT_SUPPORTED;
        end else if (cmd_i.transfer && !regno_supported(cmd_i.regno)) begin
            err_o = NOT_SUPPORTED;
        end else if (!sel_halted) begin
            err_o = HALT_RESUME;
        end

        no_transfer_o = !cmd_i.transfer;
    end

endmodule

// File: rtl/debug_abstract_cmd_ctrl.sv
// Abstract command sequencer: accepts DMI writes to command/abstractcs/data0,
// validates Access Register commands and runs one req/ack transaction per command.
module debug_abstract_cmd_ctrl
    import debug_cfg_types::*;
#(
    parameter int NUM_HARTS      = 4,
    parameter int HARTSELLEN     = 9,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dmactive,
    input  logic [HARTSELLEN-1:0]        hartsel,
    input  logic [NUM_HARTS-1:0]         hart_halted,
    input  logic                         cmd_write,
    input  logic [31:0]                  cmd_wdata,
    input  logic                         abstractcs_write,
    input  logic [31:0]                  abstractcs_wdata,
    input  logic                         data0_write,
    input  logic [31:0]                  data0_wdata,
    output logic [31:0]                  data0_rdata,
    output logic [31:0]                  abstractcs_rdata,
    output logic                         busy,
    output logic                         hart_req,
    output logic [$clog2(NUM_HARTS)-1:0] hart_id,
    output logic [15:0]                  hart_regno,
    output logic                         hart_write,
    output logic [31:0]                  hart_wdata,
    input  logic                         hart_ack,
    input  logic [31:0]                  hart_rdata,
    input  logic                         hart_err
);

    localparam int ID_W  = $clog2(NUM_HARTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    abstract_cmd_state_t          state_q;
    logic                         busy_q;
    logic                         hart_req_q;
    logic                         hart_write_q;
    logic [ID_W-1:0]              hart_id_q;
    logic [15:0]                  hart_regno_q;
    logic [31:0]                  hart_wdata_q;
    logic [31:0]                  data0_q;
    logic [2:0]                   cmderr_q;
    logic [2:0]                   cmderr_d;
    abstract_command_t            cmd_q;
    logic [HARTSELLEN-1:0]        hartsel_q;
    logic [CNT_W-1:0]             timeout_cnt_q;

    cmderr_t                      dec_err;
    logic                         dec_no_transfer;
    cmderr_t                      new_err;
    logic                         ack_valid;
    logic                         timeout_hit;
    logic                         busy_write;
    abstract_control_and_status_t cs;
    logic                         unused_cs_bits;

    debug_abstract_cmd_decode #(
        .NUM_HARTS  (NUM_HARTS),
        .HARTSELLEN (HARTSELLEN)
    ) u_decode (
        .cmd_i         (cmd_q),
        .hartsel_i     (hartsel_q),
        .hart_halted_i (hart_halted),
        .err_o         (dec_err),
        .no_transfer_o (dec_no_transfer)
    );

    assign ack_valid      = hart_req_q && hart_ack;
    assign timeout_hit    = (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy_write     = busy_q && (cmd_write || data0_write);
    assign unused_cs_bits = ^{abstractcs_wdata[31:11], abstractcs_wdata[7:0]};

    // A fresh error beats a same-cycle W1C, but nothing replaces a nonzero cmderr.
    always_comb begin
        new_err = NONE;
        case (state_q)
            CHECK: new_err = dec_err;
            REQ: begin
                if (ack_valid && hart_err) begin
                    new_err = EXCEPTION;
                end else if (!ack_valid && timeout_hit) begin
                    new_err = OTHER;
                end
            end
            default: new_err = NONE;
        endcase
        if ((new_err == NONE) && busy_write) begin
            new_err = BUSY;
        end

        cmderr_d = cmderr_q;
        if (!busy_q && abstractcs_write) begin
            cmderr_d = cmderr_q & ~abstractcs_wdata[10:8];
        end
        if ((cmderr_q == NONE) && (new_err != NONE)) begin
            cmderr_d = new_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            hart_req_q    <= 1'b0;
            hart_write_q  <= 1'b0;
            hart_id_q     <= '0;
            hart_regno_q  <= '0;
            hart_wdata_q  <= '0;
            data0_q       <= '0;
            cmderr_q      <= '0;
            cmd_q         <= '0;
            hartsel_q     <= '0;
            timeout_cnt_q <= '0;
        end else if (!dmactive) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            hart_req_q    <= 1'b0;
            hart_write_q  <= 1'b0;
            hart_id_q     <= '0;
            hart_regno_q  <= '0;
            hart_wdata_q  <= '0;
            data0_q       <= '0;
            cmderr_q      <= '0;
            cmd_q         <= '0;
            hartsel_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            cmderr_q <= cmderr_d;
            case (state_q)
                IDLE: begin
                    if (data0_write) begin
                        data0_q <= data0_wdata;
                    end
                    if (cmd_write && (cmderr_q == NONE)) begin
                        cmd_q     <= cmd_wdata;
                        hartsel_q <= hartsel;
                        state_q   <= CHECK;
                        busy_q    <= 1'b1;
                    end
                end
                CHECK: begin
                    if ((dec_err != NONE) || dec_no_transfer) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // data0 already holds any same-cycle DMI write made at accept.
                        state_q       <= REQ;
                        hart_req_q    <= 1'b1;
                        hart_id_q     <= hartsel_q[ID_W-1:0];
                        hart_regno_q  <= cmd_q.regno;
                        hart_write_q  <= cmd_q.write;
                        hart_wdata_q  <= data0_q;
                        timeout_cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (ack_valid || timeout_hit) begin
                        if (ack_valid && !hart_err && !hart_write_q) begin
                            data0_q <= hart_rdata;
                        end
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        hart_req_q    <= 1'b0;
                        timeout_cnt_q <= '0;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    hart_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cs             = '0;
        cs.progbufsize = 5'd0;
        cs.datacount   = DATACOUNT;
        cs.busy        = busy_q;
        cs.cmderr      = cmderr_q;
    end

    assign abstractcs_rdata = cs;
    assign data0_rdata      = data0_q;
    assign busy             = busy_q;
    assign hart_req         = hart_req_q;
    assign hart_id          = hart_id_q;
    assign hart_regno       = hart_regno_q;
    assign hart_write       = hart_write_q;
    assign hart_wdata       = hart_wdata_q;

endmodule

// File: tb/tb_debug_abstract_cmd_ctrl.sv
// Directed and randomized bench for debug_abstract_cmd_ctrl against a
// command-level reference model of cmderr, data0 and transaction timing.
module tb_debug_abstract_cmd_ctrl;

    localparam int NUM_HARTS  = 4;
    localparam int HARTSELLEN = 9;
    localparam int TIMEOUT    = 1023;

    logic                  clk;
    logic                  rst_n;
    logic                  dmactive;
    logic [HARTSELLEN-1:0] hartsel;
    logic [NUM_HARTS-1:0]  hart_halted;
    logic                  cmd_write;
    logic [31:0]           cmd_wdata;
    logic                  abstractcs_write;
    logic [31:0]           abstractcs_wdata;
    logic                  data0_write;
    logic [31:0]           data0_wdata;
    logic [31:0]           data0_rdata;
    logic [31:0]           abstractcs_rdata;
    logic                  busy;
    logic                  hart_req;
    logic [1:0]            hart_id;
    logic [15:0]           hart_regno;
    logic                  hart_write;
    logic [31:0]           hart_wdata;
    logic                  hart_ack;
    logic [31:0]           hart_rdata;
    logic                  hart_err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_data0;
    logic [2:0]  exp_cmderr;

    int          busy_cyc;
    int          req_cyc;
    logic [1:0]  cap_id;
    logic [15:0] cap_regno;
    logic        cap_write;
    logic [31:0] cap_wdata;
    logic        cap_stable;

    debug_abstract_cmd_ctrl #(
        .NUM_HARTS      (NUM_HARTS),
        .HARTSELLEN     (HARTSELLEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dmactive         (dmactive),
        .hartsel          (hartsel),
        .hart_halted      (hart_halted),
        .cmd_write        (cmd_write),
        .cmd_wdata        (cmd_wdata),
        .abstractcs_write (abstractcs_write),
        .abstractcs_wdata (abstractcs_wdata),
        .data0_write      (data0_write),
        .data0_wdata      (data0_wdata),
        .data0_rdata      (data0_rdata),
        .abstractcs_rdata (abstractcs_rdata),
        .busy             (busy),
        .hart_req         (hart_req),
        .hart_id          (hart_id),
        .hart_regno       (hart_regno),
        .hart_write       (hart_write),
        .hart_wdata       (hart_wdata),
        .hart_ack         (hart_ack),
        .hart_rdata       (hart_rdata),
        .hart_err         (hart_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cs_word(input logic b, input logic [2:0] e);
        return (32'(b) << 12) | (32'(e) << 8) | 32'd1;
    endfunction

    // Command legality straight from the Access Register rules, in priority order.
    function automatic logic [2:0] exp_cmd_err(input logic [31:0] c, input logic [8:0] hs,
                                               input logic [3:0] halted);
        logic [15:0] r;
        r = c[15:0];
        if (c[31:24] != 8'd0 || c[22:20] != 3'd2 || c[18]) return 3'd2;
        if (c[17] && !(r <= 16'h0FFF || (r >= 16'h1000 && r <= 16'h101F))) return 3'd2;
        if (hs >= 9'd4) return 3'd4;
        if (!halted[hs[1:0]]) return 3'd4;
        return 3'd0;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cs"}, abstractcs_rdata, cs_word(1'b0, exp_cmderr));
        chk({tag, "_data0"}, data0_rdata, exp_data0);
    endtask

    task automatic w1c(input string tag, input logic [31:0] val);
        abstractcs_write = 1'b1;
        abstractcs_wdata = val;
        tick();
        abstractcs_write = 1'b0;
        exp_cmderr = exp_cmderr & ~val[10:8];
        chk_model(tag);
    endtask

    // Issues one command, plays the hart side (ack on req cycle ack_on, 0 = never)
    // and optionally collides a cmd_write on req cycle coll_on.
    task automatic run_cmd(input logic [31:0] cmd, input logic [8:0] hs, input int ack_on,
                           input logic err, input logic [31:0] rdata, input int coll_on,
                           input logic d0_wr, input logic [31:0] d0_val);
        hartsel     = hs;
        cmd_wdata   = cmd;
        cmd_write   = 1'b1;
        data0_write = d0_wr;
        data0_wdata = d0_val;
        tick();
        cmd_write   = 1'b0;
        data0_write = 1'b0;
        busy_cyc    = 0;
        req_cyc     = 0;
        cap_stable  = 1'b1;
        for (int n = 0; n < 1100; n++) begin
            hart_ack  = 1'b0;
            cmd_write = 1'b0;
            if (!busy) break;
            busy_cyc++;
            if (hart_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    cap_id    = hart_id;
                    cap_regno = hart_regno;
                    cap_write = hart_write;
                    cap_wdata = hart_wdata;
                end else if (cap_id !== hart_id || cap_regno !== hart_regno ||
                             cap_write !== hart_write || cap_wdata !== hart_wdata) begin
                    cap_stable = 1'b0;
                end
                if (req_cyc == ack_on) begin
                    hart_ack   = 1'b1;
                    hart_err   = err;
                    hart_rdata = rdata;
                end
                if (req_cyc == coll_on) cmd_write = 1'b1;
            end
            tick();
        end
        hart_ack  = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] cmd, input logic [8:0] hs,
                          input int ack_on, input logic err, input logic [31:0] rdata,
                          input int coll_on, input logic d0_wr, input logic [31:0] d0_val);
        int          eb;
        int          er;
        logic [2:0]  e;
        logic [31:0] issue_d0;
        if (d0_wr) exp_data0 = d0_val;
        issue_d0 = exp_data0;
        eb = 0;
        er = 0;
        if (exp_cmderr == 3'd0) begin
            e  = exp_cmd_err(cmd, hs, hart_halted);
            eb = 1;
            if (e != 3'd0) begin
                exp_cmderr = e;
            end else if (cmd[17]) begin
                er = (ack_on == 0) ? TIMEOUT : ack_on;
                eb = er + 1;
                if (coll_on > 0 && coll_on <= er && coll_on != ack_on) exp_cmderr = 3'd1;
                if (ack_on == 0) begin
                    if (exp_cmderr == 3'd0) exp_cmderr = 3'd7;
                end else if (err) begin
                    if (exp_cmderr == 3'd0) exp_cmderr = 3'd3;
                end else if (!cmd[16]) begin
                    exp_data0 = rdata;
                end
            end
        end
        run_cmd(cmd, hs, ack_on, err, rdata, coll_on, d0_wr, d0_val);
        chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(eb));
        chk({tag, "_req_cycles"}, 32'(req_cyc), 32'(er));
        if (er > 0) begin
            chk({tag, "_hart_id"}, 32'(cap_id), 32'(hs[1:0]));
            chk({tag, "_regno"}, 32'(cap_regno), 32'(cmd[15:0]));
            chk({tag, "_write"}, 32'(cap_write), 32'(cmd[16]));
            chk({tag, "_wdata"}, cap_wdata, issue_d0);
            chk({tag, "_stable"}, 32'(cap_stable), 32'd1);
        end
        chk_model(tag);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] wd;
        logic [8:0]  hs;
        logic [2:0]  mask;

        rst_n            = 1'b0;
        dmactive         = 1'b1;
        hartsel          = '0;
        hart_halted      = 4'b1111;
        cmd_write        = 1'b0;
        cmd_wdata        = '0;
        abstractcs_write = 1'b0;
        abstractcs_wdata = '0;
        data0_write      = 1'b0;
        data0_wdata      = '0;
        hart_ack         = 1'b0;
        hart_rdata       = '0;
        hart_err         = 1'b0;
        exp_data0        = '0;
        exp_cmderr       = '0;

        repeat (3) tick();
        chk_model("reset");
        chk("reset_req", 32'(hart_req), 32'd0);
        chk("reset_regno", 32'(hart_regno), 32'd0);
        chk("reset_write", 32'(hart_write), 32'd0);
        rst_n = 1'b1;
        tick();

        hart_halted = 4'b0010;
        do_cmd("rd_gpr", 32'h00221005, 9'd1, 3, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        chk("rd_gpr_regno_lit", 32'(cap_regno), 32'h1005);
        chk("rd_gpr_write_lit", 32'(cap_write), 32'd0);
        chk("rd_gpr_data0_lit", data0_rdata, 32'hDEADBEEF);
        chk("rd_gpr_busy4", 32'(busy_cyc), 32'd4);

        data0_write = 1'b1;
        data0_wdata = 32'h12345678;
        tick();
        data0_write = 1'b0;
        exp_data0 = 32'h12345678;
        do_cmd("wr_csr", 32'h002307B1, 9'd1, 1, 1'b0, 32'hFFFF0000, 0, 1'b0, 32'h0);
        chk("wr_csr_wdata_lit", cap_wdata, 32'h12345678);
        chk("wr_csr_write_lit", 32'(cap_write), 32'd1);
        chk("wr_csr_busy2", 32'(busy_cyc), 32'd2);
        chk("wr_csr_data0_lit", data0_rdata, 32'h12345678);

        hart_halted = 4'b1111;
        do_cmd("size3", 32'h00321000, 9'd1, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        chk("size3_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd2));
        w1c("size3_clr", 32'h00000700);

        hart_halted = 4'b0001;
        do_cmd("not_halted", 32'h00221005, 9'd1, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        chk("not_halted_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd4));
        w1c("not_halted_clr", 32'h00000700);

        hart_halted = 4'b1111;
        do_cmd("hartsel5", 32'h00221005, 9'd5, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        chk("hartsel5_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd4));
        w1c("hartsel5_clr", 32'h00000700);
        chk("w1c_cleared", abstractcs_rdata, 32'h00000001);

        do_cmd("no_xfer", 32'h00201005, 9'd0, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);

        do_cmd("collide", 32'h00221005, 9'd2, 3, 1'b0, 32'hCAFEF00D, 1, 1'b0, 32'h0);
        chk("collide_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd1));
        chk("collide_data0", data0_rdata, 32'hCAFEF00D);
        do_cmd("ignored", 32'h00221005, 9'd2, 1, 1'b0, 32'h77777777, 0, 1'b0, 32'h0);
        chk("ignored_busy0", 32'(busy_cyc), 32'd0);
        w1c("collide_clr", 32'h00000100);

        do_cmd("exception", 32'h00221003, 9'd0, 2, 1'b1, 32'h11111111, 0, 1'b0, 32'h0);
        chk("exception_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd3));
        chk("exception_data0", data0_rdata, 32'hCAFEF00D);
        w1c("exception_clr", 32'h00000700);

        do_cmd("timeout", 32'h00221001, 9'd3, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        chk("timeout_req_cycles", 32'(req_cyc), 32'(TIMEOUT));
        chk("timeout_cmderr", abstractcs_rdata, cs_word(1'b0, 3'd7));
        w1c("timeout_clr", 32'h00000700);

        for (int it = 0; it < 40; it++) begin
            hs          = 9'($urandom_range(0, 5));
            hart_halted = 4'($urandom_range(0, 15));
            c           = $urandom;
            c[31:24]    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            c[22:20]    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            c[18]       = ($urandom_range(0, 7) == 0);
            c[17]       = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       c[15:0] = 16'($urandom_range(0, 16'h0FFF));
                1:       c[15:0] = 16'($urandom_range(16'h1000, 16'h101F));
                2:       c[15:0] = 16'($urandom_range(16'h1020, 16'hFFFF));
                default: c[15:0] = 16'($urandom_range(16'h0300, 16'h07FF));
            endcase
            do_cmd("rnd", c, hs, $urandom_range(1, 4), ($urandom_range(0, 4) == 0), $urandom,
                   0, ($urandom_range(0, 2) == 0), $urandom);
            mask     = 3'($urandom_range(0, 7));
            wd       = $urandom;
            wd[10:8] = mask;
            w1c("rnd_w1c", wd);
        end

        hart_halted = 4'b1111;
        w1c("pre_rst_clr", 32'h00000700);
        data0_write = 1'b1;
        data0_wdata = 32'hA5A5A5A5;
        tick();
        data0_write = 1'b0;
        hartsel     = 9'd1;
        cmd_wdata   = 32'h00221005;
        cmd_write   = 1'b1;
        tick();
        cmd_write = 1'b0;
        tick();
        chk("rst_pre_req", 32'(hart_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_data0  = '0;
        exp_cmderr = '0;
        chk("rst_async_req", 32'(hart_req), 32'd0);
        chk_model("rst_async");
        chk("rst_async_id", 32'(hart_id), 32'd0);
        chk("rst_async_regno", 32'(hart_regno), 32'd0);
        chk("rst_async_wdata", hart_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        hart_ack   = 1'b1;
        hart_err   = 1'b0;
        hart_rdata = 32'hBADBAD00;
        tick();
        hart_ack = 1'b0;
        chk_model("late_ack");
        chk("late_ack_req", 32'(hart_req), 32'd0);

        data0_write = 1'b1;
        data0_wdata = 32'h5A5A0001;
        tick();
        data0_write = 1'b0;
        hartsel     = 9'd2;
        cmd_wdata   = 32'h002307B1;
        cmd_write   = 1'b1;
        tick();
        cmd_write = 1'b0;
        tick();
        chk("dm_pre_req", 32'(hart_req), 32'd1);
        chk("dm_pre_id", 32'(hart_id), 32'd2);
        chk("dm_pre_wdata", hart_wdata, 32'h5A5A0001);
        dmactive = 1'b0;
        #1;
        chk("dm_sync_hold", 32'(hart_req), 32'd1);
        tick();
        exp_data0 = '0;
        chk("dm_req", 32'(hart_req), 32'd0);
        chk("dm_id", 32'(hart_id), 32'd0);
        chk("dm_regno", 32'(hart_regno), 32'd0);
        chk("dm_wdata", hart_wdata, 32'd0);
        chk("dm_write", 32'(hart_write), 32'd0);
        chk_model("dm_clear");
        dmactive = 1'b1;
        tick();
        chk_model("dm_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_abstract_cmd_ctrl.md
Name: debug_abstract_cmd_ctrl

Overview:
- Sequences RISC-V abstract "Access Register" commands inside the debug module.
- Accepts decoded DMI writes to abstract command, abstractcs and data0. Validates each command and runs a single req/ack register transaction to the selected hart.
- Maintains busy, cmderr and data0, and supplies abstractcs read data to the DMI register file.

Parameters:
- NUM_HARTS, 4, number of harts attached. Valid hart indices are 0..NUM_HARTS-1.
- HARTSELLEN, 9, width of the hartsel field from dmcontrol.
- TIMEOUT_CYCLES, 1023, maximum cycles spent in REQ before the command is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dmactive  in  1  dmcontrol.dmactive. 0 synchronously clears the block to its reset state.
- hartsel  in  HARTSELLEN  currently selected hart
- hart_halted  in  NUM_HARTS  per-hart halted status
- cmd_write  in  1  DMI write strobe to ABSTRACT_COMMAND (0x17)
- cmd_wdata  in  32  command word, abstract_command_t layout
- abstractcs_write  in  1  DMI write strobe to ABSTRACT_CONTROL_AND_STATUS (0x16)
- abstractcs_wdata  in  32  write data. Bits [10:8] are W1C for cmderr.
- data0_write  in  1  DMI write strobe to ABSTRACT_DATA0 (0x04)
- data0_wdata  in  32  data0 write data
- data0_rdata  out  32  current data0
- abstractcs_rdata  out  32  abstract_control_and_status_t: progsize=0, datacount=1, busy, cmderr
- busy  out  1  command in progress
- hart_req  out  1  register access request
- hart_id  out  $clog2(NUM_HARTS)  target hart
- hart_regno  out  16  register number (0x0000-0x0FFF CSR, 0x1000-0x101F GPR)
- hart_write  out  1  1 = write hart register, 0 = read
- hart_wdata  out  32  write data (data0 captured at issue)
- hart_ack  in  1  transaction complete. Valid only while hart_req=1.
- hart_rdata  in  32  read data, valid with hart_ack
- hart_err  in  1  hart raised an exception, valid with hart_ack

Behaviour:
- Reset (rst_n=0, asynchronous) and dmactive=0 (synchronous):
  - state=IDLE; busy, hart_req, hart_write = 0.
  - cmderr=0, data0=0, hart_id=0, hart_regno=0, hart_wdata=0, timeout counter=0.
  - Reset mid-REQ drops hart_req immediately. An ack arriving after that is ignored.
- States: IDLE, CHECK, REQ.
  - busy=1 exactly when state is CHECK or REQ. busy is a registered output.
- IDLE, on cmd_write:
  - If cmderr!=0, the command is ignored and state stays IDLE.
  - Otherwise latch cmd_wdata, hartsel and data0, then go to CHECK.
- CHECK (always 1 cycle). Checks are applied in this priority order:
  1. cmdtype!=0 -> cmderr=2
  2. size!=2 -> cmderr=2
  3. postexec=1 -> cmderr=2
  4. transfer=1 with regno outside the CSR/GPR ranges -> cmderr=2
  5. hartsel>=NUM_HARTS or hart not halted -> cmderr=4
- CHECK outcome:
  - Any error -> IDLE.
  - Else transfer=0 -> IDLE with no hart access and cmderr unchanged.
  - Else -> REQ.
- REQ:
  - hart_req=1, with hart_id/regno/write/wdata held stable until ack.
  - hart_ack may arrive in the first REQ cycle.
  - On ack with write=0 and hart_err=0: data0 <= hart_rdata.
  - On ack with hart_err=1: cmderr=3 and data0 unchanged.
  - Either way, go to IDLE and deassert hart_req in the next cycle.
- Timeout:
  - A counter increments for each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES: cmderr=7, state -> IDLE, and the counter clears.
- Minimum latency: cmd_write in cycle N -> CHECK in N+1 -> REQ in N+2 (ack same cycle) -> busy=0 in N+3.
- Writes while busy=1:
  - cmd_write, data0_write and abstractcs_write(cmderr) are ignored.
  - cmd_write and data0_write additionally set cmderr=1, only if cmderr was 0.
- cmderr update rules:
  - While idle, W1C clears each set bit of cmderr written as 1.
  - If a W1C and a new error occur in the same cycle, the new error wins.
  - cmderr is never overwritten while nonzero, except by clearing.
- data0_write in IDLE updates data0 on the next edge.
- A data0_write and cmd_write in the same IDLE cycle: data0 is written first, and the command latches the new value.

Decomposition:
- Add to debug_cfg_types:
  - abstract_cmd_state_t enum {IDLE, CHECK, REQ}.
  - cmderr_t enum: NONE=0, BUSY=1, NOT_SUPPORTED=2, EXCEPTION=3, HALT_RESUME=4, OTHER=7.
  - Regno range constants GPR_BASE=16'h1000, GPR_LAST=16'h101F, CSR_LAST=16'h0FFF.
  - ACCESS_REGISTER cmdtype = 8'd0.
- Sub-module: debug_abstract_cmd_decode. It is combinational; it maps the latched command, hartsel and hart_halted to a cmderr_t result plus a "no transfer" flag. It is used in CHECK.

Test Plan:
- Read GPR: hart 1 halted, hartsel=1, cmd_wdata=0x00221005, hart_ack with hart_rdata=0xDEADBEEF on the 3rd REQ cycle -> hart_regno=0x1005, hart_write=0, data0_rdata=0xDEADBEEF, cmderr=0, busy high exactly 4 cycles.
- Write CSR: data0_write 0x12345678, then cmd_wdata=0x002307B1, ack in the same cycle as req -> hart_wdata=0x12345678, hart_write=1, busy high 2 cycles, data0 unchanged.
- Errors:
  - size=3 (0x00321000) -> cmderr=2, no hart_req.
  - Hart not halted -> cmderr=4.
  - hartsel=5 -> cmderr=4.
  - W1C 0x00000700 -> cmderr=0.
- Busy collision: cmd_write during REQ -> cmderr=1 and the original command completes. A second cmd_write while cmderr=1 -> ignored, busy stays 0.
- Exception and timeout:
  - Ack with hart_err=1 -> cmderr=3, data0 unchanged.
  - No ack -> hart_req drops after TIMEOUT_CYCLES cycles, cmderr=7.
- Reset mid-operation: rst_n low during REQ -> hart_req=0 asynchronously and all outputs at reset values. dmactive=0 during REQ -> same, at the next edge.
